// File: rtl/alu_result_buffer.sv
// Registered FWFT result FIFO behind the combinational ALU units, with sticky
// flag status and a saturating count of flag-set results accepted.
module alu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [31:0]                res_data,
  input  logic                       res_flag,
  input  logic [TAG_W-1:0]           res_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic                       out_flag,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       sticky_flag,
  output logic [CNT_W-1:0]           flag_cnt,
  input  logic                       clr_status
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  typedef struct packed {
    logic [31:0]      data;
    logic             flag;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  logic   [AW-1:0]    rptr, wptr;
  logic               push, pop;
  entry_t             head;

  assign res_ready = (occupancy != FULL);
  assign out_valid = (occupancy != '0);
  assign push      = res_valid && res_ready;
  assign pop       = out_valid && out_ready;

  // Head is gated by out_valid so an empty buffer always presents zeros.
  assign head     = out_valid ? mem[rptr] : '0;
  assign out_data = head.data;
  assign out_flag = head.flag;
  assign out_tag  = head.tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem       <= '0;
      rptr      <= '0;
      wptr      <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= '{data: res_data, flag: res_flag, tag: res_tag};
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // A flag-set push beats a coincident clear: the count restarts at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flag <= 1'b0;
      flag_cnt    <= '0;
    end else if (push && res_flag) begin
      sticky_flag <= 1'b1;
      if (clr_status)     flag_cnt <= CNT_W'(1);
      else if (!(&flag_cnt)) flag_cnt <= flag_cnt + CNT_W'(1);
    end else if (clr_status) begin
      sticky_flag <= 1'b0;
      flag_cnt    <= '0;
    end
  end
endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomized + directed bench for alu_result_buffer against a queue-based model.
module tb_alu_result_buffer;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic res_valid, res_ready, res_flag, out_valid, out_ready, out_flag;
  logic sticky_flag, clr_status;
  logic [31:0] res_data, out_data;
  logic [TAG_W-1:0] res_tag, out_tag;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0] flag_cnt;

  alu_result_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flag(res_flag), .res_tag(res_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flag(out_flag), .out_tag(out_tag),
    .occupancy(occupancy), .sticky_flag(sticky_flag), .flag_cnt(flag_cnt),
    .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      d;
    logic             f;
    logic [TAG_W-1:0] t;
  } ent_t;

  ent_t q[$];
  bit   m_sticky;
  int   m_cnt;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input string name);
    chk({name, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
    chk({name, ".res_ready"}, 64'(res_ready), 64'(q.size() < DEPTH));
    chk({name, ".occupancy"}, 64'(occupancy), 64'(q.size()));
    if (q.size() != 0) begin
      chk({name, ".out_data"}, 64'(out_data), 64'(q[0].d));
      chk({name, ".out_flag"}, 64'(out_flag), 64'(q[0].f));
      chk({name, ".out_tag"},  64'(out_tag),  64'(q[0].t));
    end
    chk({name, ".sticky"},   64'(sticky_flag), 64'(m_sticky));
    chk({name, ".flag_cnt"}, 64'(flag_cnt),    64'(m_cnt));
  endtask

  // One clock: drive at negedge, model the edge, check at the next negedge.
  task automatic cyc(input string name, input logic v, input logic [31:0] d,
                     input logic f, input logic [TAG_W-1:0] t,
                     input logic ordy, input logic clr);
    bit push, pop;
    res_valid = v; res_data = d; res_flag = f; res_tag = t;
    out_ready = ordy; clr_status = clr;
    push = v && (q.size() < DEPTH);
    pop  = ordy && (q.size() > 0);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) q.push_back('{d: d, f: f, t: t});
    if (push && f) begin
      m_sticky = 1'b1;
      m_cnt    = clr ? 1 : ((m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1);
    end else if (clr) begin
      m_sticky = 1'b0;
      m_cnt    = 0;
    end
    @(negedge clk);
    check_all(name);
  endtask

  task automatic model_reset();
    q.delete();
    m_sticky = 1'b0;
    m_cnt    = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    res_valid = 0; res_data = '0; res_flag = 0; res_tag = '0;
    out_ready = 0; clr_status = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all("reset");
    chk("reset.out_data0", 64'(out_data), 64'h0);
    cyc("idle", 0, '0, 0, '0, 0, 0);

    // Compare-unit style results: all-ones then zero with flag.
    cyc("p1", 1, 32'hFFFF_FFFF, 0, 5'd3, 1, 0);
    chk("p1.head", {31'b0, out_flag, out_tag, out_data}, {31'b0, 1'b0, 5'd3, 32'hFFFF_FFFF});
    cyc("p2", 1, 32'h0, 1, 5'd7, 1, 0);
    chk("p2.head", {31'b0, out_flag, out_tag, out_data}, {31'b0, 1'b1, 5'd7, 32'h0});
    chk("p2.cnt", 64'(flag_cnt), 64'd1);
    cyc("drain", 0, '0, 0, '0, 1, 0);

    // Fill with out_ready low; the fifth result stays held until a pop.
    for (int i = 0; i < 5; i++) begin
      cyc("fill", 1, 32'h100 + 32'(i), 0, 5'(i), 0, 0);
      while (i == 4 && q.size() == DEPTH && !res_ready && q[DEPTH-1].d != 32'h104) begin
        chk("full.occ", 64'(occupancy), 64'(DEPTH));
        cyc("full.hold", 1, 32'h104, 0, 5'd4, 0, 0);
        cyc("full.pop", 1, 32'h104, 0, 5'd4, 1, 0);
      end
    end
    for (int i = 0; i < 6; i++) cyc("full.drain", 0, '0, 0, '0, 1, 0);

    // Steady push+pop at occupancy 2 across pointer wrap.
    cyc("w.fill0", 1, 32'hA0, 0, 5'd0, 0, 0);
    cyc("w.fill1", 1, 32'hA1, 0, 5'd1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc("wrap", 1, 32'hB0 + 32'(i), 0, 5'(i), 1, 0);
      chk("wrap.occ2", 64'(occupancy), 64'd2);
    end
    for (int i = 0; i < 3; i++) cyc("w.drain", 0, '0, 0, '0, 1, 0);

    // clr_status racing a flag push.
    cyc("c.clr", 0, '0, 0, '0, 1, 1);
    for (int i = 0; i < 5; i++) cyc("c.flag", 1, 32'h0, 1, 5'd9, 1, 0);
    chk("c.cnt5", 64'(flag_cnt), 64'd5);
    cyc("c.race", 1, 32'h0, 1, 5'd9, 1, 1);
    chk("c.race.cnt", 64'(flag_cnt), 64'd1);
    chk("c.race.sticky", 64'(sticky_flag), 64'd1);
    cyc("c.only", 0, '0, 0, '0, 1, 1);
    chk("c.only.cnt", 64'(flag_cnt), 64'd0);
    chk("c.only.sticky", 64'(sticky_flag), 64'd0);

    // Saturation.
    for (int i = 0; i < CMAX + 3; i++) cyc("sat", 1, 32'h0, 1, 5'd1, 1, 0);
    chk("sat.cnt", 64'(flag_cnt), 64'(CMAX));

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cyc("rnd", 1'($urandom_range(0, 9) < 6), $urandom, 1'($urandom),
          5'($urandom), 1'($urandom), 1'($urandom_range(0, 15) == 0));

    // Asynchronous reset mid-stream with three entries held.
    for (int i = 0; i < DEPTH; i++) cyc("ar.drain", 0, '0, 0, '0, 1, 0);
    for (int i = 0; i < 3; i++) cyc("ar.fill", 1, 32'hC0 + 32'(i), 1, 5'(i), 0, 0);
    res_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    chk("arst.out_data0", 64'(out_data), 64'h0);
    @(posedge clk);
    @(negedge clk);
    check_all("arst.hold");
    rst_n = 1'b1;
    cyc("arst.rel", 0, '0, 0, '0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
